// File: rtl/register_bank_pkg.sv
// Shared op encoding for register_bank and its cells.
package register_bank_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD = 2'b00;
  localparam op_t OP_LOAD = 2'b01;
  localparam op_t OP_INC  = 2'b10;
  localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit storage cell with hold/load/increment/clear and an increment carry-out.
module register_cell
  import register_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  op_t              op,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    unique case (op)
      OP_HOLD: value_d = value_q;
      OP_LOAD: value_d = in;
      OP_INC:  value_d = value_q + WIDTH'(1);
      OP_CLR:  value_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  // High only while an increment of an all-ones value is pending on this cell.
  assign carry = (op == OP_INC) && (&value_q);

endmodule

// File: rtl/register_bank.sv
// Bank of DEPTH registers: one op-coded write port, two combinational read ports, wrap pulse.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  op_t               op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  out_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  out_b,
  output logic              wrap
);

  logic [WIDTH-1:0] values [DEPTH];
  op_t              cell_op [DEPTH];
  logic [DEPTH-1:0] carry;
  logic             wrap_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    // Only the addressed cell sees the op; every other cell holds.
    assign cell_op[i] = (waddr == ADDR_W'(i)) ? op : OP_HOLD;

    register_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .op   (cell_op[i]),
      .in   (in),
      .value(values[i]),
      .carry(carry[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= |carry;
    end
  end

  assign wrap  = wrap_q;
  assign out_a = values[raddr_a];
  assign out_b = values[raddr_b];

endmodule
